alu_mul_ctrl: RTL and testbench
===============================

Name: alu_mul_ctrl

Overview:
- Sequencing controller between the EXU issue logic and the shared multiplier top (rs1/rs2 data, signedness flags, mul_valid/mul_ready handshake, 2*XLEN product).
- Decodes RV64M multiply ops (MUL, MULH, MULHSU, MULHU, MULW) into signedness controls and launches one multiply at a time.
- Selects and formats the XLEN result half, and holds it until the consumer accepts it.
- Absorbs pipeline flushes by draining an in-flight multiply and discarding its product.

Parameters:
XLEN, 64, datapath width; product bus is 2*XLEN.
OP_W, 3, width of op code.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
req_valid_i  in  1  issue request valid
req_ready_o  out  1  controller can accept a request
req_op_i  in  OP_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal
req_rs1_i  in  XLEN  operand 1
req_rs2_i  in  XLEN  operand 2
flush_i  in  1  kill current op (pipeline flush)
res_valid_o  out  1  result valid
res_ready_i  in  1  consumer accepts result
res_data_o  out  XLEN  formatted result
mul_valid_o  out  1  launch/hold multiply
mul_ready_i  in  1  product valid this cycle
mul_rs1_signed_o  out  1  rs1 signed flag to multiplier
mul_rs2_signed_o  out  1  rs2 signed flag to multiplier
mul_rs1_o  out  XLEN  operand 1 to multiplier (registered)
mul_rs2_o  out  XLEN  operand 2 to multiplier (registered)
mul_out_i  in  2*XLEN  product from multiplier

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; req_ready_o=1, res_valid_o=0, mul_valid_o=0, signed flags=0, operand/result registers=0. Reset mid-operation abandons everything; the multiplier is reset by the same rst.
- FSM states: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o&!flush_i with a legal op: latch op, operands and signed flags, then go to BUSY. mul_valid_o rises the next cycle.
  - On an illegal op: res_data=0, go to DONE. The multiplier is not used.
- BUSY:
  - mul_valid_o=1; operands and flags held stable.
  - On mul_ready_i: capture and format the result, drop mul_valid_o next cycle, go to DONE.
  - If flush_i (with or without mul_ready_i): go to DRAIN, unless mul_ready_i is also asserted that cycle, in which case go to IDLE and discard the product.
- DRAIN:
  - mul_valid_o stays 1 until mul_ready_i; the product is discarded; then go to IDLE.
  - req_ready_o=0 and res_valid_o=0 throughout.
- DONE:
  - res_valid_o=1; res_data_o held.
  - On res_ready_i: go to IDLE. No same-cycle new accept (req_ready_o=0 in DONE).
  - flush_i in DONE: go to IDLE and drop the result. Flush has priority over res_ready_i.
- Signedness:
  - MUL: u/u.
  - MULH: s/s.
  - MULHSU: s/u.
  - MULHU: u/u.
  - MULW: u/u.
- Result formatting:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - MULW: sign-extend product[31:0] to XLEN.
- flush_i in IDLE blocks acceptance that cycle (req_ready_o still 1, but no transaction).
- Latency (no cache): accept at T, mul_valid_o=1 from T+1, mul_ready_i at T+k, res_valid_o at T+k+1.
- Throughput: one op in flight. res_valid_o and mul_valid_o are never both 1.

Optional Feature:
- Macro: ALU_MUL_CTRL_CACHE_EN.
- With the macro defined:
  - Keep last full product plus rs1, rs2 and signed flags (cache valid bit cleared by reset, flush during BUSY/DRAIN, and illegal ops).
  - A new legal request whose operands and flags match goes IDLE -> DONE directly (res_valid_o at T+1) and does not assert mul_valid_o.
  - Enables MULH+MUL fusion at 1-cycle cost.
- Without the macro: every legal op goes through BUSY; no product storage.

Decomposition:
- Shared package/header (alongside sysconfig): op code constants (MUL_OP_MUL..MUL_OP_MULW), FSM state encodings, XLEN taken from the existing config define.
- One natural sub-module, alu_mul_fmt: combinational op -> signed flags decode and product -> result formatting. The FSM and registers stay in alu_mul_ctrl.

Test Plan:
- MUL rs1=3, rs2=5, mul_ready_i 4 cycles after mul_valid_o -> res_data_o=15, res_valid_o exactly one cycle after mul_ready_i; mul_valid_o held stable 4 cycles.
- MULH rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> flags s/s, res_data_o=0. MULHU same operands -> flags u/u, res_data_o=0xFFFF_FFFF_FFFF_FFFE.
- MULW rs1=0x0000_0000_8000_0000, rs2=1 -> res_data_o=0xFFFF_FFFF_8000_0000.
- flush_i one cycle into BUSY -> mul_valid_o stays 1 until mul_ready_i, res_valid_o never asserts, req_ready_o returns 1 the cycle after mul_ready_i.
- res_ready_i held 0 for 5 cycles in DONE -> res_valid_o/res_data_o stable, req_ready_o=0; op=6 -> res_data_o=0 at T+1, mul_valid_o never asserts; rst=0 in BUSY -> all outputs at reset values next cycle.
- ALU_MUL_CTRL_CACHE_EN: MULH then MUL on rs1=7, rs2=9 -> second returns 63 at T+1 with no mul_valid_o; changing rs2 to 10 forces a real multiply.

Source files
------------

// File: rtl/alu_mul_ctrl_pkg.sv
// Shared definitions for the multiply sequencing controller: datapath width, op codes, FSM states.
// The product cache is gated by ALU_MUL_CTRL_CACHE_EN.
package alu_mul_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] mul_op_t;

    localparam mul_op_t MUL_OP_MUL    = 3'd0;
    localparam mul_op_t MUL_OP_MULH   = 3'd1;
    localparam mul_op_t MUL_OP_MULHSU = 3'd2;
    localparam mul_op_t MUL_OP_MULHU  = 3'd3;
    localparam mul_op_t MUL_OP_MULW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Ops that read only low product bits, which do not depend on operand signedness.
    function automatic logic op_is_low_half(mul_op_t op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULW);
    endfunction

endpackage

// File: rtl/alu_mul_ctrl_if.sv
// Issue, result and multiplier handshake bundle of alu_mul_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline and multiplier.
interface alu_mul_ctrl_if;
    import alu_mul_ctrl_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    mul_op_t           req_op_i;
    logic [XLEN-1:0]   req_rs1_i;
    logic [XLEN-1:0]   req_rs2_i;
    logic              flush_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [XLEN-1:0]   res_data_o;
    logic              mul_valid_o;
    logic              mul_ready_i;
    logic              mul_rs1_signed_o;
    logic              mul_rs2_signed_o;
    logic [XLEN-1:0]   mul_rs1_o;
    logic [XLEN-1:0]   mul_rs2_o;
    logic [2*XLEN-1:0] mul_out_i;

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i,
        input  res_ready_i, mul_ready_i, mul_out_i,
        output req_ready_o, res_valid_o, res_data_o,
        output mul_valid_o, mul_rs1_signed_o, mul_rs2_signed_o, mul_rs1_o, mul_rs2_o
    );

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i,
        output res_ready_i, mul_ready_i, mul_out_i,
        input  req_ready_o, res_valid_o, res_data_o,
        input  mul_valid_o, mul_rs1_signed_o, mul_rs2_signed_o, mul_rs1_o, mul_rs2_o
    );

endinterface

// File: rtl/alu_mul_fmt.sv
// Combinational RV64M multiply decode: op -> operand signedness and legality,
// and full product -> architectural XLEN result.
module alu_mul_fmt
    import alu_mul_ctrl_pkg::*;
(
    input  mul_op_t           op_i,
    input  logic [2*XLEN-1:0] product_i,
    output logic              legal_o,
    output logic              rs1_signed_o,
    output logic              rs2_signed_o,
    output logic [XLEN-1:0]   result_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        legal_o      = 1'b1;
        rs1_signed_o = 1'b0;
        rs2_signed_o = 1'b0;
        result_o     = '0;
        unique case (op_i)
            MUL_OP_MUL: begin
                result_o = product_i[XLEN-1:0];
            end
            MUL_OP_MULH: begin
                rs1_signed_o = 1'b1;
                rs2_signed_o = 1'b1;
                result_o     = product_i[2*XLEN-1:XLEN];
            end
            MUL_OP_MULHSU: begin
                rs1_signed_o = 1'b1;
                result_o     = product_i[2*XLEN-1:XLEN];
            end
            MUL_OP_MULHU: begin
                result_o = product_i[2*XLEN-1:XLEN];
            end
            MUL_OP_MULW: begin
                result_o = {{(XLEN-32){product_i[31]}}, product_i[31:0]};
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mul_ctrl.sv
// Sequences one multiply at a time between EXU issue and the shared multiplier, holding the
// formatted result until accepted and draining flushed multiplies. ALU_MUL_CTRL_CACHE_EN adds a last-product cache.
module alu_mul_ctrl
    import alu_mul_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_mul_ctrl_if.slave bus
);

    state_e          state_q, state_d;
    mul_op_t         op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            rs1_signed_q, rs1_signed_d;
    logic            rs2_signed_q, rs2_signed_d;

    mul_op_t           fmt_op;
    logic [2*XLEN-1:0] fmt_product;
    logic              fmt_legal;
    logic              fmt_rs1_signed;
    logic              fmt_rs2_signed;
    logic [XLEN-1:0]   fmt_result;
    logic              cache_hit;

    // In IDLE the decoder looks at the incoming request; otherwise it formats the in-flight op.
    assign fmt_op = (state_q == ST_IDLE) ? bus.req_op_i : op_q;

`ifdef ALU_MUL_CTRL_CACHE_EN
    logic              cache_vld_q, cache_vld_d;
    logic              cache_load;
    logic [2*XLEN-1:0] cache_prod_q;

    // The cache key reuses the operand/flag registers: they only change when a new multiply launches.
    assign fmt_product = (state_q == ST_IDLE) ? cache_prod_q : bus.mul_out_i;
    assign cache_hit   = cache_vld_q
                         && (bus.req_rs1_i == rs1_q)
                         && (bus.req_rs2_i == rs2_q)
                         && (op_is_low_half(bus.req_op_i)
                             || ((fmt_rs1_signed == rs1_signed_q) && (fmt_rs2_signed == rs2_signed_q)));
`else
    assign fmt_product = bus.mul_out_i;
    assign cache_hit   = 1'b0;
`endif

    alu_mul_fmt u_fmt (
        .op_i         (fmt_op),
        .product_i    (fmt_product),
        .legal_o      (fmt_legal),
        .rs1_signed_o (fmt_rs1_signed),
        .rs2_signed_o (fmt_rs2_signed),
        .result_o     (fmt_result)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        res_d        = res_q;
        rs1_signed_d = rs1_signed_q;
        rs2_signed_d = rs2_signed_q;
`ifdef ALU_MUL_CTRL_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_load   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    if (!fmt_legal) begin
                        res_d   = '0;
                        state_d = ST_DONE;
`ifdef ALU_MUL_CTRL_CACHE_EN
                        cache_vld_d = 1'b0;
`endif
                    end else if (cache_hit) begin
                        res_d   = fmt_result;
                        state_d = ST_DONE;
                    end else begin
                        op_d         = bus.req_op_i;
                        rs1_d        = bus.req_rs1_i;
                        rs2_d        = bus.req_rs2_i;
                        rs1_signed_d = fmt_rs1_signed;
                        rs2_signed_d = fmt_rs2_signed;
                        state_d      = ST_BUSY;
`ifdef ALU_MUL_CTRL_CACHE_EN
                        cache_vld_d = 1'b0;
`endif
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mul_ready_i) begin
                    if (bus.flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        res_d   = fmt_result;
                        state_d = ST_DONE;
`ifdef ALU_MUL_CTRL_CACHE_EN
                        cache_vld_d = 1'b1;
                        cache_load  = 1'b1;
`endif
                    end
                end else if (bus.flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.mul_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (bus.flush_i || bus.res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= MUL_OP_MUL;
            rs1_q        <= '0;
            rs2_q        <= '0;
            res_q        <= '0;
            rs1_signed_q <= 1'b0;
            rs2_signed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            res_q        <= res_d;
            rs1_signed_q <= rs1_signed_d;
            rs2_signed_q <= rs2_signed_d;
        end
    end

`ifdef ALU_MUL_CTRL_CACHE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
        end else begin
            cache_vld_q <= cache_vld_d;
        end
    end

    // NOTE: the product storage has no reset; cache_vld_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (cache_load) begin
            cache_prod_q <= bus.mul_out_i;
        end
    end
`endif

    assign bus.req_ready_o      = (state_q == ST_IDLE);
    assign bus.res_valid_o      = (state_q == ST_DONE);
    assign bus.res_data_o       = res_q;
    assign bus.mul_valid_o      = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
    assign bus.mul_rs1_signed_o = rs1_signed_q;
    assign bus.mul_rs2_signed_o = rs2_signed_q;
    assign bus.mul_rs1_o        = rs1_q;
    assign bus.mul_rs2_o        = rs2_q;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Scoreboard bench for alu_mul_ctrl with a behavioural multiplier of programmable latency.
// Cache-specific expectations follow ALU_MUL_CTRL_CACHE_EN.
module tb_alu_mul_ctrl;
    import alu_mul_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mul_ctrl_if bus ();

    alu_mul_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int mul_lat = 1;
    logic [XLEN-1:0] exp_q[$];

    function automatic logic [2*XLEN-1:0] full_prod(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                                    logic sa, logic sb);
        logic [2*XLEN-1:0] ea;
        logic [2*XLEN-1:0] eb;
        ea = sa ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = sb ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic logic [XLEN-1:0] model(logic [OP_W-1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        case (op)
            3'd0: begin p = full_prod(a, b, 1'b0, 1'b0); return p[XLEN-1:0]; end
            3'd1: begin p = full_prod(a, b, 1'b1, 1'b1); return p[2*XLEN-1:XLEN]; end
            3'd2: begin p = full_prod(a, b, 1'b1, 1'b0); return p[2*XLEN-1:XLEN]; end
            3'd3: begin p = full_prod(a, b, 1'b0, 1'b0); return p[2*XLEN-1:XLEN]; end
            3'd4: begin p = full_prod(a, b, 1'b0, 1'b0); return {{(XLEN-32){p[31]}}, p[31:0]}; end
            default: return '0;
        endcase
    endfunction

    // Multiplier: answers mul_ready_i on the mul_lat-th cycle that mul_valid_o is seen high.
    initial begin : mul_model
        int cnt;
        cnt = 0;
        bus.mul_ready_i = 1'b0;
        bus.mul_out_i   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !bus.mul_valid_o || bus.mul_ready_i) begin
                cnt             = 0;
                bus.mul_ready_i = 1'b0;
                bus.mul_out_i   = {4{$urandom}};
            end else begin
                cnt++;
                if (cnt >= mul_lat) begin
                    bus.mul_ready_i = 1'b1;
                    bus.mul_out_i   = full_prod(bus.mul_rs1_o, bus.mul_rs2_o,
                                                bus.mul_rs1_signed_o, bus.mul_rs2_signed_o);
                end
            end
        end
    end

    initial begin : monitor
        logic [XLEN-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (bus.res_valid_o && bus.mul_valid_o) begin
                    errors++;
                    $display("FAIL exclusive_valid: res_valid_o=%b mul_valid_o=%b, required not both 1 (t=%0t)",
                             bus.res_valid_o, bus.mul_valid_o, $time);
                end
                if (bus.res_valid_o && bus.res_ready_i && !bus.flush_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got result %h, required no result (t=%0t)", bus.res_data_o, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        if (bus.res_data_o !== exp) begin
                            errors++;
                            $display("FAIL sb_data: got %h, required %h (t=%0t)", bus.res_data_o, exp, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit push);
        bit acc;
        acc = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_rs1_i   = a;
        bus.req_rs2_i   = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = bus.req_ready_o && !bus.flush_i;
            tick();
        end
        bus.req_valid_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL issue_timeout: request op=%0d not accepted, required accept", op);
        end else if (push) begin
            exp_q.push_back(model(op, a, b));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (exp_q.size() == 0 && bus.req_ready_o) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: pending=%0d req_ready_o=%b, required 0 and 1", exp_q.size(), bus.req_ready_o);
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        rst             = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = '0;
        bus.req_rs1_i   = '0;
        bus.req_rs2_i   = '0;
        bus.flush_i     = 1'b0;
        bus.res_ready_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [4:0] ctl;
        ctl = {bus.req_ready_o, bus.res_valid_o, bus.mul_valid_o, bus.mul_rs1_signed_o, bus.mul_rs2_signed_o};
        checks++;
        if (ctl !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl: got {rdy,rval,mval,s1,s2}=%b, required 10000", ctl);
        end
        checks++;
        if (bus.mul_rs1_o !== '0 || bus.mul_rs2_o !== '0) begin
            errors++;
            $display("FAIL reset_operands: got %h/%h, required 0/0", bus.mul_rs1_o, bus.mul_rs2_o);
        end
        checks++;
        if (bus.res_data_o !== '0) begin
            errors++;
            $display("FAIL reset_res_data: got %h, required 0", bus.res_data_o);
        end
    endtask

    task automatic test_mul_latency();
        int  valid_cycles;
        int  ready_idx;
        int  res_idx;
        bit  stable;
        valid_cycles = 0;
        ready_idx    = -1;
        res_idx      = -1;
        stable       = 1'b1;
        mul_lat = 4;
        bus.res_ready_i = 1'b1;
        issue(MUL_OP_MUL, 64'd3, 64'd5, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (bus.mul_valid_o) begin
                valid_cycles++;
                if (bus.mul_rs1_o !== 64'd3 || bus.mul_rs2_o !== 64'd5) stable = 1'b0;
            end
            if (bus.mul_ready_i && ready_idx < 0) ready_idx = c;
            if (bus.res_valid_o && res_idx < 0) begin
                res_idx = c;
                checks++;
                if (bus.res_data_o !== 64'd15) begin
                    errors++;
                    $display("FAIL mul_value: got %h, required %h", bus.res_data_o, 64'd15);
                end
            end
            tick();
        end
        checks++;
        if (valid_cycles != 4 || !stable) begin
            errors++;
            $display("FAIL mul_valid_hold: got %0d cycles stable=%b, required 4 cycles stable=1", valid_cycles, stable);
        end
        checks++;
        if (ready_idx != 3 || res_idx != 4) begin
            errors++;
            $display("FAIL mul_latency: got ready@%0d res@%0d, required ready@3 res@4", ready_idx, res_idx);
        end
        wait_idle();
    endtask

    task automatic run_signed(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic es1, input logic es2, input logic [XLEN-1:0] exp_val);
        bit seen;
        seen = 1'b0;
        mul_lat = 2;
        bus.res_ready_i = 1'b1;
        issue(op, a, b, 1'b1);
        checks++;
        if (!(bus.mul_valid_o && bus.mul_rs1_signed_o === es1 && bus.mul_rs2_signed_o === es2)) begin
            errors++;
            $display("FAIL flags_op%0d: got mval=%b s1=%b s2=%b, required mval=1 s1=%b s2=%b",
                     op, bus.mul_valid_o, bus.mul_rs1_signed_o, bus.mul_rs2_signed_o, es1, es2);
        end
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.res_valid_o) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || bus.res_data_o !== exp_val) begin
            errors++;
            $display("FAIL result_op%0d: got valid=%b data=%h, required valid=1 data=%h", op, seen, bus.res_data_o, exp_val);
        end
        wait_idle();
    endtask

    task automatic test_signedness();
        run_signed(MUL_OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'h0);
        run_signed(MUL_OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        run_signed(MUL_OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_signed(MUL_OP_MULW,   64'h0000_0000_8000_0000, 64'h1,                   1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000);
    endtask

    task automatic test_flush_busy();
        bit bad_res;
        bit valid_dropped;
        bit early_ready;
        int rdy_idx;
        logic ready_after;
        bad_res       = 1'b0;
        valid_dropped = 1'b0;
        early_ready   = 1'b0;
        rdy_idx       = -1;
        ready_after   = 1'b0;
        mul_lat = 4;
        bus.res_ready_i = 1'b1;
        issue(MUL_OP_MUL, 64'd11, 64'd13, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (bus.res_valid_o) bad_res = 1'b1;
            if (rdy_idx >= 0 && c == rdy_idx + 1) ready_after = bus.req_ready_o;
            if (rdy_idx < 0 && !bus.mul_valid_o) valid_dropped = 1'b1;
            if (rdy_idx < 0 && bus.req_ready_o) early_ready = 1'b1;
            if (rdy_idx < 0 && bus.mul_ready_i) rdy_idx = c;
            bus.flush_i = (c == 0);
            tick();
        end
        bus.flush_i = 1'b0;
        checks++;
        if (bad_res) begin
            errors++;
            $display("FAIL drain_res_valid: got res_valid_o=1 during drain, required 0");
        end
        checks++;
        if (valid_dropped || rdy_idx != 3) begin
            errors++;
            $display("FAIL drain_mul_valid: got dropped=%b ready@%0d, required dropped=0 ready@3", valid_dropped, rdy_idx);
        end
        checks++;
        if (early_ready || ready_after !== 1'b1) begin
            errors++;
            $display("FAIL drain_req_ready: got early=%b after=%b, required early=0 after=1", early_ready, ready_after);
        end
        // Flush on the same cycle as mul_ready_i goes straight back to IDLE.
        mul_lat = 1;
        issue(MUL_OP_MUL, 64'd2, 64'd2, 1'b0);
        checks++;
        if (!(bus.mul_valid_o && bus.mul_ready_i)) begin
            errors++;
            $display("FAIL flush_ready_setup: got mval=%b mrdy=%b, required 1/1", bus.mul_valid_o, bus.mul_ready_i);
        end
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checks++;
        if ({bus.req_ready_o, bus.res_valid_o, bus.mul_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL flush_with_ready: got {rdy,rval,mval}=%b, required 100",
                     {bus.req_ready_o, bus.res_valid_o, bus.mul_valid_o});
        end
        issue(MUL_OP_MUL, 64'd6, 64'd7, 1'b1);
        wait_idle();
    endtask

    task automatic test_done_hold();
        bit seen;
        seen = 1'b0;
        mul_lat = 2;
        bus.res_ready_i = 1'b0;
        issue(MUL_OP_MUL, 64'h1234, 64'h10, 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.res_valid_o) seen = 1'b1;
            else tick();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!(bus.res_valid_o && bus.res_data_o === 64'h12340 && !bus.req_ready_o)) begin
                errors++;
                $display("FAIL done_hold_%0d: got rval=%b data=%h rdy=%b, required 1/%h/0",
                         k, bus.res_valid_o, bus.res_data_o, bus.req_ready_o, 64'h12340);
            end
            tick();
        end
        bus.res_ready_i = 1'b1;
        wait_idle();
        // Flush wins over res_ready_i in DONE: result dropped.
        bus.res_ready_i = 1'b0;
        issue(MUL_OP_MUL, 64'd5, 64'd5, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.res_valid_o) seen = 1'b1;
            else tick();
        end
        bus.flush_i     = 1'b1;
        bus.res_ready_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checks++;
        if (!seen || bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got seen=%b rval=%b rdy=%b, required 1/0/1", seen, bus.res_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_illegal();
        bit mval_seen;
        mval_seen = 1'b0;
        bus.res_ready_i = 1'b1;
        issue(3'd6, 64'd3, 64'd4, 1'b1);
        checks++;
        if (!(bus.res_valid_o && bus.res_data_o === '0 && !bus.mul_valid_o)) begin
            errors++;
            $display("FAIL illegal_op: got rval=%b data=%h mval=%b, required 1/0/0",
                     bus.res_valid_o, bus.res_data_o, bus.mul_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.mul_valid_o) mval_seen = 1'b1;
            tick();
        end
        checks++;
        if (mval_seen) begin
            errors++;
            $display("FAIL illegal_no_mul: got mul_valid_o=1, required 0");
        end
        issue(3'd7, 64'd9, 64'd9, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_busy();
        logic [4:0] ctl;
        mul_lat = 10;
        issue(MUL_OP_MULH, 64'd9, 64'd9, 1'b0);
        rst = 1'b0;
        tick();
        ctl = {bus.req_ready_o, bus.res_valid_o, bus.mul_valid_o, bus.mul_rs1_signed_o, bus.mul_rs2_signed_o};
        checks++;
        if (ctl !== 5'b10000 || bus.mul_rs1_o !== '0 || bus.mul_rs2_o !== '0) begin
            errors++;
            $display("FAIL reset_busy: got ctl=%b rs1=%h rs2=%h, required 10000/0/0", ctl, bus.mul_rs1_o, bus.mul_rs2_o);
        end
        rst = 1'b1;
        tick();
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        bus.res_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = OP_W'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end else begin
                a = XLEN'($urandom_range(0, 1000));
                b = XLEN'($urandom_range(0, 1000));
            end
            mul_lat = $urandom_range(1, 4);
            issue(op, a, b, 1'b1);
        end
        wait_idle();
    endtask

    task automatic test_cache();
        mul_lat = 3;
        bus.res_ready_i = 1'b1;
        issue(MUL_OP_MULH, 64'd7, 64'd9, 1'b1);
        wait_idle();
        issue(MUL_OP_MUL, 64'd7, 64'd9, 1'b1);
        checks++;
`ifdef ALU_MUL_CTRL_CACHE_EN
        if (!(bus.res_valid_o && !bus.mul_valid_o && bus.res_data_o === 64'd63)) begin
            errors++;
            $display("FAIL cache_hit: got rval=%b mval=%b data=%h, required 1/0/%h",
                     bus.res_valid_o, bus.mul_valid_o, bus.res_data_o, 64'd63);
        end
`else
        if (!(bus.mul_valid_o && !bus.res_valid_o)) begin
            errors++;
            $display("FAIL no_cache_launch: got mval=%b rval=%b, required 1/0", bus.mul_valid_o, bus.res_valid_o);
        end
`endif
        wait_idle();
        issue(MUL_OP_MUL, 64'd7, 64'd10, 1'b1);
        checks++;
        if (!(bus.mul_valid_o && !bus.res_valid_o)) begin
            errors++;
            $display("FAIL cache_miss: got mval=%b rval=%b, required 1/0", bus.mul_valid_o, bus.res_valid_o);
        end
        wait_idle();
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_mul_latency();
        test_signedness();
        test_flush_busy();
        test_done_hold();
        test_illegal();
        test_reset_busy();
        test_back_to_back();
        test_cache();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
